param_dispatcher: RTL and testbench

PARAM_DISPATCHER -- requirements
Module: param_dispatcher

---
 rtl/param_dispatcher.sv | 142 ++++++++++++++
 tb/tb_param_dispatcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_dispatcher.sv
// Parameter loader: routes a stream of (addr, data) words to per-core write ports,
// one registered cycle after acceptance, with auto-advance or explicit core selection.
module param_dispatcher #(
  parameter int unsigned NUM_CORES     = 6,
  parameter int unsigned SKIP_CORE     = 5,
  parameter int unsigned DATA_WIDTH    = 368,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned ROWS_PER_CORE = 256,
  parameter int unsigned AUTO_ADVANCE  = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [ADDR_WIDTH-1:0]        in_addr,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic [$clog2(NUM_CORES)-1:0] core_sel,
  output logic [NUM_CORES-1:0]         out_wen,
  output logic [ADDR_WIDTH-1:0]        out_addr,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CORES)-1:0] cur_core,
  output logic                         core_done,
  output logic                         load_done,
  output logic                         busy,
  output logic                         err_addr,
  output logic                         err_drop
);

  localparam int unsigned CW = $clog2(NUM_CORES);
  localparam logic [CW-1:0] FIRST_SLOT = CW'((SKIP_CORE == 0) ? 1 : 0);
  localparam logic [CW-1:0] LAST_SLOT  =
    CW'((SKIP_CORE == NUM_CORES - 1) ? NUM_CORES - 2 : NUM_CORES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ROWS_PER_CORE - 1);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cur_d;
  logic [ADDR_WIDTH-1:0]   row, row_d;
  logic [NUM_CORES-1:0]    wen_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic                    cdone_d, ldone_d, busy_d, eaddr_d, edrop_d;
  logic                    sel_ok_c;

  // Successor slot in auto mode, stepping over the output-bus slot.
  function automatic logic [CW-1:0] next_slot(input logic [CW-1:0] c);
    logic [CW-1:0] n;
    n = c + CW'(1);
    if (32'(n) == SKIP_CORE) n = n + CW'(1);
    return n;
  endfunction

  assign sel_ok_c = (32'(core_sel) < NUM_CORES) && (32'(core_sel) != SKIP_CORE);

  always_comb begin
    state_d = state;
    cur_d   = cur_core;
    row_d   = row;
    wen_d   = '0;
    addr_d  = out_addr;
    data_d  = out_data;
    cdone_d = 1'b0;
    ldone_d = load_done;
    eaddr_d = err_addr;
    edrop_d = err_drop;
    if (start) begin
      // Restart clears errors, except a word arriving in this very cycle is a fresh drop.
      state_d = LOAD;
      cur_d   = FIRST_SLOT;
      row_d   = '0;
      ldone_d = 1'b0;
      eaddr_d = 1'b0;
      edrop_d = in_valid;
    end else if (state == LOAD && in_valid) begin
      if (AUTO_ADVANCE != 0) begin
        wen_d  = NUM_CORES'(1) << cur_core;
        addr_d = in_addr;
        data_d = in_data;
        if (in_addr != row) eaddr_d = 1'b1;
        if (row == LAST_ROW) begin
          cdone_d = 1'b1;
          row_d   = '0;
          if (cur_core == LAST_SLOT) begin
            state_d = DONE;
            ldone_d = 1'b1;
          end else begin
            cur_d = next_slot(cur_core);
          end
        end else begin
          row_d = row + ADDR_WIDTH'(1);
        end
      end else if (sel_ok_c) begin
        wen_d  = NUM_CORES'(1) << core_sel;
        cur_d  = core_sel;
        addr_d = in_addr;
        data_d = in_data;
        if (in_addr == LAST_ROW) begin
          cdone_d = 1'b1;
          if (core_sel == LAST_SLOT) begin
            state_d = DONE;
            ldone_d = 1'b1;
          end
        end
      end else begin
        edrop_d = 1'b1;
      end
    end else if (in_valid) begin
      edrop_d = 1'b1;
    end
    busy_d = (state_d == LOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_core  <= '0;
      row       <= '0;
      out_wen   <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      core_done <= 1'b0;
      load_done <= 1'b0;
      busy      <= 1'b0;
      err_addr  <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      state     <= state_d;
      cur_core  <= cur_d;
      row       <= row_d;
      out_wen   <= wen_d;
      out_addr  <= addr_d;
      out_data  <= data_d;
      core_done <= cdone_d;
      load_done <= ldone_d;
      busy      <= busy_d;
      err_addr  <= eaddr_d;
      err_drop  <= edrop_d;
    end
  end

endmodule

// File: tb/tb_param_dispatcher.sv
// Directed bench: auto-advance instance driven from a vector table, plus an
// explicit-select instance and reset-mid-load exercised by hand-written sequences.
module tb_param_dispatcher;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic [2:0]    core_sel;
  logic [5:0]    out_wen;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [2:0]    cur_core;
  logic          core_done, load_done, busy, err_addr, err_drop;

  logic          start_b, in_valid_b;
  logic [AW-1:0] in_addr_b;
  logic [DW-1:0] in_data_b;
  logic [2:0]    core_sel_b;
  logic [5:0]    out_wen_b;
  logic [AW-1:0] out_addr_b;
  logic [DW-1:0] out_data_b;
  logic [2:0]    cur_core_b;
  logic          core_done_b, load_done_b, busy_b, err_addr_b, err_drop_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  param_dispatcher #(.NUM_CORES(6), .SKIP_CORE(5), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .ROWS_PER_CORE(4), .AUTO_ADVANCE(1)) dut_auto (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
    .in_addr(in_addr), .in_data(in_data), .core_sel(core_sel),
    .out_wen(out_wen), .out_addr(out_addr), .out_data(out_data),
    .cur_core(cur_core), .core_done(core_done), .load_done(load_done),
    .busy(busy), .err_addr(err_addr), .err_drop(err_drop));

  param_dispatcher #(.NUM_CORES(6), .SKIP_CORE(5), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                     .ROWS_PER_CORE(4), .AUTO_ADVANCE(0)) dut_expl (
    .clk(clk), .reset_n(reset_n), .start(start_b), .in_valid(in_valid_b),
    .in_addr(in_addr_b), .in_data(in_data_b), .core_sel(core_sel_b),
    .out_wen(out_wen_b), .out_addr(out_addr_b), .out_data(out_data_b),
    .cur_core(cur_core_b), .core_done(core_done_b), .load_done(load_done_b),
    .busy(busy_b), .err_addr(err_addr_b), .err_drop(err_drop_b));

  typedef struct {
    logic          st;
    logic          iv;
    logic [AW-1:0] a;
    logic [5:0]    wen;
    logic          cd;
    logic          ld;
    logic          ea;
    logic          ed;
    logic          bz;
    logic [2:0]    cur;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic iv, input int a,
                              input logic [5:0] wen, input logic cd, input logic ld,
                              input logic ea, input logic ed, input logic bz,
                              input int cur);
    vec_t v;
    v.st = st; v.iv = iv; v.a = AW'(a); v.wen = wen; v.cd = cd; v.ld = ld;
    v.ea = ea; v.ed = ed; v.bz = bz; v.cur = 3'(cur);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    vec_t v;

    reset_n = 1'b0;
    start = 0; in_valid = 0; in_addr = '0; in_data = '0; core_sel = '0;
    start_b = 0; in_valid_b = 0; in_addr_b = '0; in_data_b = '0; core_sel_b = '0;
    exp_addr = '0;
    exp_data = '0;

    // Vector table for the auto-advance instance (ROWS_PER_CORE = 4).
    vecs.push_back(mk(0, 1, 0, 6'd0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0));
    for (int k = 0; k < 20; k++) begin
      int c;
      int r;
      c = k / 4;
      r = k % 4;
      vecs.push_back(mk(0, 1, r, 6'(1 << c), r == 3, k == 19, 0, 0, k != 19,
                        (r == 3 && k != 19) ? c + 1 : c));
    end
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 1, 0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 0, 6'd0, 0, 1, 0, 1, 0, 4));
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 6'd1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 6'd1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 6'd1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3, 6'd1, 1, 0, 1, 0, 1, 1));
    for (int r = 0; r < 4; r++)
      vecs.push_back(mk(0, 1, r, 6'd2, r == 3, 0, 1, 0, 1, (r == 3) ? 2 : 1));
    vecs.push_back(mk(0, 1, 0, 6'd4, 0, 0, 1, 0, 1, 2));
    vecs.push_back(mk(1, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 6'd1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 5, 6'd0, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 6'd0, 0, 0, 0, 1, 1, 0));

    step();
    step();
    chk("reset_auto", {out_wen, out_addr, out_data, cur_core, core_done, load_done,
                       busy, err_addr, err_drop}, 64'd0);
    chk("reset_expl", {out_wen_b, out_addr_b, out_data_b, cur_core_b, core_done_b,
                       load_done_b, busy_b, err_addr_b, err_drop_b}, 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      start    = v.st;
      in_valid = v.iv;
      in_addr  = v.a;
      in_data  = 32'hC0DE_0000 | 32'(i);
      step();
      if (v.wen != 0) begin
        exp_addr = v.a;
        exp_data = in_data;
      end
      chk($sformatf("v%0d_wen", i), 64'(out_wen), 64'(v.wen));
      chk($sformatf("v%0d_addr", i), 64'(out_addr), 64'(exp_addr));
      chk($sformatf("v%0d_data", i), 64'(out_data), 64'(exp_data));
      chk($sformatf("v%0d_flags", i),
          64'({core_done, load_done, err_addr, err_drop, busy}),
          64'({v.cd, v.ld, v.ea, v.ed, v.bz}));
      chk($sformatf("v%0d_cur", i), 64'(cur_core), 64'(v.cur));
    end
    start = 0;
    in_valid = 0;

    // Reset mid-load: get into core 1, then pull reset with a word presented.
    start = 1; step(); start = 0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1; in_addr = AW'(k % 4); step();
    end
    chk("pre_reset_cur", 64'(cur_core), 64'd1);
    in_valid = 1; in_addr = 8'd1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {out_wen, out_addr, out_data, cur_core, core_done, load_done,
                        busy, err_addr, err_drop}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_reset_wen", 64'(out_wen), 64'd0);
    chk("post_reset_flags", 64'({err_drop, busy, load_done, cur_core}), 64'({1'b1, 1'b0, 1'b0, 3'd0}));
    in_valid = 0;

    // Explicit-select instance.
    start_b = 1; step(); start_b = 0;
    chk("expl_start_busy", 64'(busy_b), 64'd1);
    in_valid_b = 1; core_sel_b = 3'd3; in_addr_b = 8'd3; in_data_b = 32'h1234_5678;
    step();
    chk("expl_sel3_wen", 64'(out_wen_b), 64'h08);
    chk("expl_sel3_done", 64'({core_done_b, load_done_b, cur_core_b, out_addr_b}),
        64'({1'b1, 1'b0, 3'd3, 8'd3}));
    chk("expl_sel3_data", 64'(out_data_b), 64'h1234_5678);
    core_sel_b = 3'd5; in_addr_b = 8'd0; in_data_b = 32'hDEAD_BEEF;
    step();
    chk("expl_skip_wen", 64'(out_wen_b), 64'd0);
    chk("expl_skip_drop", 64'({err_drop_b, core_done_b, out_data_b}),
        64'({1'b1, 1'b0, 32'h1234_5678}));
    core_sel_b = 3'd6;
    step();
    chk("expl_range_wen", 64'(out_wen_b), 64'd0);
    core_sel_b = 3'd0; in_addr_b = 8'd3;
    step();
    chk("expl_sel0", 64'({out_wen_b, core_done_b, load_done_b, busy_b}),
        64'({6'h01, 1'b1, 1'b0, 1'b1}));
    core_sel_b = 3'd4; in_addr_b = 8'd3;
    step();
    chk("expl_last", 64'({out_wen_b, core_done_b, load_done_b, busy_b, err_drop_b}),
        64'({6'h10, 1'b1, 1'b1, 1'b0, 1'b1}));
    in_valid_b = 0;
    step();
    chk("expl_hold", 64'({out_wen_b, core_done_b, load_done_b}), 64'({6'h00, 1'b0, 1'b1}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
